// File: rtl/wqe_cache_pkg.sv
// wqe_cache_pkg: shared types for the WQE class cache.
// Class codes, WRID field bounds and map entry.
package wqe_cache_pkg;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_LS   = 2'd1;
  localparam logic [1:0] CLS_BS   = 2'd2;
  localparam logic [1:0] CLS_RSV  = 2'd3;

  localparam int WRID_LSB = 0;
  localparam int WRID_MSB = 63;
  localparam int WRID_W   = 64;

  localparam int SLOT_MAX_W = 8;

  typedef struct packed {
    logic [1:0]            cls;
    logic [SLOT_MAX_W-1:0] slot;
  } map_t;

endpackage

// File: rtl/wqe_sfifo.sv
// wqe_sfifo: sync FIFO, registered read port,
// occupancy counter, full/alfull/empty flags.
module wqe_sfifo
  import wqe_cache_pkg::*;
#(
  parameter int W      = 512,
  parameter int DL2    = 4,
  parameter int MARGIN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_alfull
);

  localparam int DEPTH = 1 << DL2;
  localparam logic [DL2:0] C_FULL =
    (DL2+1)'(DEPTH);
  localparam logic [DL2:0] C_AF =
    (DL2+1)'(DEPTH - MARGIN);

  logic [W-1:0]   r_mem [DEPTH];
  logic [DL2-1:0] r_wptr;
  logic [DL2-1:0] r_rptr;
  logic [DL2:0]   r_cnt;
  logic [W-1:0]   r_rdata;
  logic           w_push;
  logic           w_pop;

  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == C_FULL);
  assign o_alfull = (r_cnt >= C_AF);
  assign o_rdata  = r_rdata;

  // full/empty are pre-edge: no bypass,
  // and push into full drops even if popped
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/wqe_class_cache.sv
// wqe_class_cache: classify WQEs by QPN into
// one LS FIFO or BS slot FIFOs; per-QP flags.
module wqe_class_cache
  import wqe_cache_pkg::*;
#(
  parameter int WQE_WIDTH     = 512,
  parameter int MAX_QP        = 16,
  parameter int QP_PTR_WIDTH  = 4,
  parameter int BS_SLOT_NUM   = 4,
  parameter int SLOT_W        = 2,
  parameter int LS_DEPTH_LOG2 = 4,
  parameter int BS_DEPTH_LOG2 = 4,
  parameter int ALFULL_MARGIN = 1,
  parameter int QPID_LSB      = 328
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wqe_cache_wr,
  input  logic [WQE_WIDTH-1:0]    i_wqe,
  output logic [MAX_QP-1:0]       o_wqe_cache_alfull,
  output logic [MAX_QP-1:0]       o_wqe_cache_full,
  input  logic                    i_cfg_wr,
  input  logic [QP_PTR_WIDTH-1:0] i_cfg_qpn,
  input  logic [1:0]              i_cfg_class,
  input  logic [SLOT_W-1:0]       i_cfg_slot,
  output logic                    o_ls_wqe_empty,
  input  logic                    i_ls_wqe_ren,
  output logic [WQE_WIDTH-1:0]    o_ls_wqe_rdata,
  output logic [BS_SLOT_NUM-1:0]  o_bs_fifo_empty,
  input  logic [BS_SLOT_NUM-1:0]  i_bs_fifo_rd,
  output logic                    o_bs_wqe_val,
  output logic [WQE_WIDTH-1:0]    o_bs_wqe,
  output logic [SLOT_W-1:0]       o_bs_wqe_slot,
  output logic                    o_wr_val,
  output logic [QP_PTR_WIDTH-1:0] o_wr_qpn,
  output logic [WRID_W-1:0]       o_wr_wrid,
  output logic                    o_drop,
  output logic                    o_rd_err
);

  map_t r_map [MAX_QP];

  logic [QP_PTR_WIDTH-1:0] w_qpn;
  map_t                    w_ent;
  logic [SLOT_W-1:0]       w_slot;
  logic                    w_ls;
  logic                    w_bs;
  logic                    w_tgt_full;
  logic                    w_acc;
  logic                    w_drop;
  logic                    w_ls_full;
  logic                    w_ls_af;
  logic [BS_SLOT_NUM-1:0]  w_bs_full;
  logic [BS_SLOT_NUM-1:0]  w_bs_af;
  logic [BS_SLOT_NUM-1:0]  w_bs_push;
  logic [BS_SLOT_NUM-1:0]  w_bs_pop;
  logic [BS_SLOT_NUM-1:0]  w_bs_pop_ok;
  logic                    w_multi;
  logic [SLOT_W-1:0]       w_pop_idx;
  logic [WQE_WIDTH-1:0]    w_bs_rdata [BS_SLOT_NUM];
  logic                    w_unused;

  logic                    r_wr_val;
  logic [QP_PTR_WIDTH-1:0] r_wr_qpn;
  logic [WRID_W-1:0]       r_wr_wrid;
  logic                    r_drop;
  logic                    r_bs_val;
  logic                    r_rd_err;
  logic [SLOT_W-1:0]       r_slot;

  function automatic map_t dflt(int q);
    map_t e;
    e.cls  = CLS_NONE;
    e.slot = '0;
    if (q == 0) begin
      e.cls = CLS_LS;
    end else if ((q % 2 == 1) &&
                 ((q >> 1) < BS_SLOT_NUM)) begin
      e.cls  = CLS_BS;
      e.slot = SLOT_MAX_W'(q >> 1);
    end
    return e;
  endfunction

  function automatic logic slot_ok(map_t e);
    return 32'(e.slot) < BS_SLOT_NUM;
  endfunction

  assign w_unused = ^i_wqe;
  assign w_qpn    = i_wqe[QPID_LSB +: QP_PTR_WIDTH];
  assign w_ent    = r_map[w_qpn];
  assign w_slot   = w_ent.slot[SLOT_W-1:0];

  always_comb begin
    w_ls = 1'b0;
    w_bs = 1'b0;
    unique case (1'b1)
      (w_ent.cls == CLS_LS): w_ls = 1'b1;
      (w_ent.cls == CLS_BS): w_bs = slot_ok(w_ent);
      default: ;
    endcase
  end

  always_comb begin
    w_tgt_full = 1'b1;
    if (w_ls) w_tgt_full = w_ls_full;
    else if (w_bs) w_tgt_full = w_bs_full[w_slot];
  end

  assign w_acc  = i_wqe_cache_wr && !w_tgt_full;
  assign w_drop = i_wqe_cache_wr && w_tgt_full;

  always_comb begin
    o_wqe_cache_full   = '1;
    o_wqe_cache_alfull = '1;
    for (int q = 0; q < MAX_QP; q++) begin
      if (r_map[q].cls == CLS_LS) begin
        o_wqe_cache_full[q]   = w_ls_full;
        o_wqe_cache_alfull[q] = w_ls_af;
      end else if (r_map[q].cls == CLS_BS &&
                   slot_ok(r_map[q])) begin
        o_wqe_cache_full[q] =
          w_bs_full[r_map[q].slot[SLOT_W-1:0]];
        o_wqe_cache_alfull[q] =
          w_bs_af[r_map[q].slot[SLOT_W-1:0]];
      end
    end
  end

  // multi-hot read request pops nothing
  assign w_multi = (i_bs_fifo_rd &
    (i_bs_fifo_rd - BS_SLOT_NUM'(1))) != '0;
  assign w_bs_pop    = w_multi ? '0 : i_bs_fifo_rd;
  assign w_bs_pop_ok = w_bs_pop & ~o_bs_fifo_empty;

  always_comb begin
    w_pop_idx = '0;
    for (int s = 0; s < BS_SLOT_NUM; s++) begin
      if (w_bs_pop_ok[s]) w_pop_idx = SLOT_W'(s);
    end
  end

  always_comb begin
    w_bs_push = '0;
    for (int s = 0; s < BS_SLOT_NUM; s++) begin
      if (i_wqe_cache_wr && w_bs &&
          32'(w_slot) == s)
        w_bs_push[s] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < MAX_QP; q++)
        r_map[q] <= dflt(q);
    end else if (i_cfg_wr) begin
      r_map[i_cfg_qpn].cls  <= i_cfg_class;
      r_map[i_cfg_qpn].slot <=
        SLOT_MAX_W'(i_cfg_slot);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_val  <= 1'b0;
      r_wr_qpn  <= '0;
      r_wr_wrid <= '0;
      r_drop    <= 1'b0;
      r_bs_val  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_slot    <= '0;
    end else begin
      r_wr_val <= w_acc;
      r_drop   <= w_drop;
      if (i_wqe_cache_wr) begin
        r_wr_qpn  <= w_qpn;
        r_wr_wrid <= i_wqe[WRID_MSB:WRID_LSB];
      end
      r_bs_val <= |w_bs_pop_ok;
      r_rd_err <= w_multi;
      if (|w_bs_pop_ok) r_slot <= w_pop_idx;
    end
  end

  wqe_sfifo #(
    .W      (WQE_WIDTH),
    .DL2    (LS_DEPTH_LOG2),
    .MARGIN (ALFULL_MARGIN)
  ) u_ls (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (i_wqe_cache_wr && w_ls),
    .i_wdata  (i_wqe),
    .i_pop    (i_ls_wqe_ren),
    .o_rdata  (o_ls_wqe_rdata),
    .o_empty  (o_ls_wqe_empty),
    .o_full   (w_ls_full),
    .o_alfull (w_ls_af)
  );

  for (genvar s = 0; s < BS_SLOT_NUM; s++)
  begin : g_bs
    wqe_sfifo #(
      .W      (WQE_WIDTH),
      .DL2    (BS_DEPTH_LOG2),
      .MARGIN (ALFULL_MARGIN)
    ) u_bs (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_bs_push[s]),
      .i_wdata  (i_wqe),
      .i_pop    (w_bs_pop[s]),
      .o_rdata  (w_bs_rdata[s]),
      .o_empty  (o_bs_fifo_empty[s]),
      .o_full   (w_bs_full[s]),
      .o_alfull (w_bs_af[s])
    );
  end

  assign o_wr_val      = r_wr_val;
  assign o_wr_qpn      = r_wr_qpn;
  assign o_wr_wrid     = r_wr_wrid;
  assign o_drop        = r_drop;
  assign o_bs_wqe_val  = r_bs_val;
  assign o_rd_err      = r_rd_err;
  assign o_bs_wqe_slot = r_slot;
  assign o_bs_wqe      = w_bs_rdata[r_slot];

endmodule

// File: tb/tb_wqe_class_cache.sv
// tb_wqe_class_cache: directed vectors plus
// sequences for full, wrap, remap and reset.
module tb_wqe_class_cache;

  localparam int QL = 328;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr = 1'b0;
  logic [511:0] wqe = '0;
  logic [15:0]  alfull;
  logic [15:0]  full;
  logic         cfg_wr = 1'b0;
  logic [3:0]   cfg_qpn = '0;
  logic [1:0]   cfg_cls = '0;
  logic [1:0]   cfg_slot = '0;
  logic         ls_empty;
  logic         ls_ren = 1'b0;
  logic [511:0] ls_rdata;
  logic [3:0]   bs_empty;
  logic [3:0]   bs_rd = '0;
  logic         bs_val;
  logic [511:0] bs_wqe;
  logic [1:0]   bs_slot;
  logic         wr_val;
  logic [3:0]   wr_qpn;
  logic [63:0]  wr_wrid;
  logic         drop;
  logic         rd_err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  wqe_class_cache dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_wqe_cache_wr     (wr),
    .i_wqe              (wqe),
    .o_wqe_cache_alfull (alfull),
    .o_wqe_cache_full   (full),
    .i_cfg_wr           (cfg_wr),
    .i_cfg_qpn          (cfg_qpn),
    .i_cfg_class        (cfg_cls),
    .i_cfg_slot         (cfg_slot),
    .o_ls_wqe_empty     (ls_empty),
    .i_ls_wqe_ren       (ls_ren),
    .o_ls_wqe_rdata     (ls_rdata),
    .o_bs_fifo_empty    (bs_empty),
    .i_bs_fifo_rd       (bs_rd),
    .o_bs_wqe_val       (bs_val),
    .o_bs_wqe           (bs_wqe),
    .o_bs_wqe_slot      (bs_slot),
    .o_wr_val           (wr_val),
    .o_wr_qpn           (wr_qpn),
    .o_wr_wrid          (wr_wrid),
    .o_drop             (drop),
    .o_rd_err           (rd_err)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  qpn;
    logic [63:0] id;
    logic [3:0]  rd;
    logic        lsr;
    logic        e_wv;
    logic        e_drop;
    logic        e_err;
    logic        e_bv;
    logic [1:0]  e_slot;
    logic        e_lse;
    logic [3:0]  e_bse;
    logic        e_lsd;
    logic [63:0] e_id;
  } vec_t;

  vec_t v [9];

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s: got %0h want %0h",
               n, a, e);
    else
      pass_cnt++;
  endtask

  task automatic step(input logic w,
                      input logic [3:0] q,
                      input logic [63:0] id,
                      input logic [3:0] rd,
                      input logic lr);
    wr = w;
    wqe = '0;
    wqe[QL +: 4] = q;
    wqe[63:0] = id;
    bs_rd = rd;
    ls_ren = lr;
    @(posedge clk);
    #1;
    wr = 1'b0;
    bs_rd = '0;
    ls_ren = 1'b0;
    cfg_wr = 1'b0;
  endtask

  initial begin
    v[0] = '{1'b1, 4'd0, 64'hA0, 4'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
             1'b0, 4'hF, 1'b0, 64'hA0};
    v[1] = '{1'b1, 4'd5, 64'hA5, 4'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
             1'b0, 4'hB, 1'b0, 64'hA5};
    v[2] = '{1'b0, 4'd0, 64'h0, 4'h1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
             1'b0, 4'hB, 1'b0, 64'h0};
    v[3] = '{1'b0, 4'd0, 64'h0, 4'h3, 1'b0,
             1'b0, 1'b0, 1'b1, 1'b0, 2'd0,
             1'b0, 4'hB, 1'b0, 64'h0};
    v[4] = '{1'b0, 4'd0, 64'h0, 4'h4, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, 2'd2,
             1'b0, 4'hF, 1'b0, 64'hA5};
    v[5] = '{1'b1, 4'd4, 64'hB4, 4'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b0, 2'd0,
             1'b0, 4'hF, 1'b0, 64'h0};
    v[6] = '{1'b1, 4'd9, 64'hB9, 4'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b0, 2'd0,
             1'b0, 4'hF, 1'b0, 64'h0};
    v[7] = '{1'b0, 4'd0, 64'h0, 4'h0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
             1'b1, 4'hF, 1'b1, 64'hA0};
    v[8] = '{1'b0, 4'd0, 64'h0, 4'h0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
             1'b1, 4'hF, 1'b1, 64'hA0};

    #12;
    chk("rst_full", 64'(full), 64'hFF54);
    chk("rst_alfull", 64'(alfull), 64'hFF54);
    chk("rst_ls_empty", 64'(ls_empty), 1);
    chk("rst_bs_empty", 64'(bs_empty), 64'hF);
    chk("rst_flags", 64'({wr_val, drop,
        bs_val, rd_err}), 0);
    chk("rst_slot", 64'(bs_slot), 0);
    chk("rst_bs_data", 64'(|bs_wqe), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      step(v[i].wr, v[i].qpn, v[i].id,
           v[i].rd, v[i].lsr);
      chk($sformatf("v%0d_wr_val", i),
          64'(wr_val), 64'(v[i].e_wv));
      chk($sformatf("v%0d_drop", i),
          64'(drop), 64'(v[i].e_drop));
      chk($sformatf("v%0d_rd_err", i),
          64'(rd_err), 64'(v[i].e_err));
      chk($sformatf("v%0d_bs_val", i),
          64'(bs_val), 64'(v[i].e_bv));
      chk($sformatf("v%0d_ls_empty", i),
          64'(ls_empty), 64'(v[i].e_lse));
      chk($sformatf("v%0d_bs_empty", i),
          64'(bs_empty), 64'(v[i].e_bse));
      if (v[i].e_wv) begin
        chk($sformatf("v%0d_wrid", i),
            wr_wrid, v[i].e_id);
        chk($sformatf("v%0d_qpn", i),
            64'(wr_qpn), 64'(v[i].qpn));
      end
      if (v[i].e_bv) begin
        chk($sformatf("v%0d_bs_id", i),
            bs_wqe[63:0], v[i].e_id);
        chk($sformatf("v%0d_bs_slot", i),
            64'(bs_slot), 64'(v[i].e_slot));
      end
      if (v[i].e_lsd)
        chk($sformatf("v%0d_ls_id", i),
            ls_rdata[63:0], v[i].e_id);
    end

    for (int i = 0; i < 17; i++) begin
      step(1'b1, 4'd1, 64'(100 + i), 4'h0, 1'b0);
      if (i == 13)
        chk("af_14", 64'(alfull[1]), 0);
      if (i == 14) begin
        chk("af_15", 64'(alfull[1]), 1);
        chk("full_15", 64'(full[1]), 0);
      end
      if (i == 15)
        chk("full_16", 64'(full[1]), 1);
      if (i == 16) begin
        chk("drop_17", 64'(drop), 1);
        chk("wv_17", 64'(wr_val), 0);
      end
    end
    step(1'b1, 4'd1, 64'd200, 4'h1, 1'b0);
    chk("pp_drop", 64'(drop), 1);
    chk("pp_bv", 64'(bs_val), 1);
    chk("pp_id", bs_wqe[63:0], 64'd100);
    chk("pp_full", 64'(full[1]), 0);
    chk("pp_af", 64'(alfull[1]), 1);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 4'd0, 64'd0, 4'h1, 1'b0);
      chk($sformatf("drain_%0d", i),
          bs_wqe[63:0], 64'(100 + i));
    end
    chk("drain_empty", 64'(bs_empty), 64'hF);

    step(1'b1, 4'd3, 64'd1000, 4'h0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 4'd3, 64'(1000 + i),
           4'h2, 1'b0);
      chk($sformatf("wrap_%0d", i),
          bs_wqe[63:0], 64'(999 + i));
      chk($sformatf("wrap_v%0d", i),
          64'({bs_val, bs_slot, wr_val}),
          64'(4'b1011));
    end
    step(1'b0, 4'd0, 64'd0, 4'h2, 1'b0);
    chk("wrap_last", bs_wqe[63:0], 64'd1040);
    chk("wrap_empty", 64'(bs_empty), 64'hF);

    cfg_wr = 1'b1;
    cfg_qpn = 4'd2;
    cfg_cls = 2'd2;
    cfg_slot = 2'd3;
    step(1'b0, 4'd0, 64'd0, 4'h0, 1'b0);
    chk("remap_full0", 64'(full[2]), 0);
    step(1'b1, 4'd2, 64'd300, 4'h0, 1'b0);
    chk("remap_wv", 64'(wr_val), 1);
    chk("remap_bse", 64'(bs_empty), 64'h7);
    for (int i = 1; i < 16; i++)
      step(1'b1, 4'd2, 64'(300 + i), 4'h0, 1'b0);
    chk("remap_full2", 64'(full[2]), 1);
    chk("remap_full7", 64'(full[7]), 1);
    chk("remap_af2", 64'(alfull[2]), 1);

    cfg_wr = 1'b1;
    cfg_qpn = 4'd6;
    cfg_cls = 2'd1;
    cfg_slot = 2'd0;
    step(1'b1, 4'd6, 64'd600, 4'h0, 1'b0);
    chk("same_cyc_drop", 64'(drop), 1);
    step(1'b1, 4'd6, 64'd601, 4'h0, 1'b0);
    chk("new_map_wv", 64'(wr_val), 1);
    chk("new_map_lse", 64'(ls_empty), 0);
    step(1'b1, 4'd0, 64'd602, 4'h0, 1'b0);
    step(1'b1, 4'd0, 64'd603, 4'h0, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ls_empty", 64'(ls_empty), 1);
    chk("mid_bs_empty", 64'(bs_empty), 64'hF);
    chk("mid_full", 64'(full), 64'hFF54);
    chk("mid_alfull", 64'(alfull), 64'hFF54);
    chk("mid_wv", 64'(wr_val), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 4'd0, 64'd0, 4'h8, 1'b1);
    chk("post_bv", 64'(bs_val), 0);
    chk("post_ls_data", 64'(|ls_rdata), 0);
    chk("post_bs_data", 64'(|bs_wqe), 0);
    chk("post_ls_empty", 64'(ls_empty), 1);

    $display("%0d/%0d checks passed",
             pass_cnt, total);
    $finish;
  end

endmodule
